// File: rtl/hw_vector_sequencer.sv
// ============================================================================
//  Module      : hw_vector_sequencer
//  Description : Applies stimulus vectors to the helloWorld x-pads, waits a
//                programmable settle time, samples z and reports a masked
//                pass/fail result with saturating pass/fail counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hw_vector_sequencer #(
    parameter int NUM_IN  = 39,
    parameter int NUM_OUT = 3,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 16
) (
    input  logic               my_clk,
    input  logic               my_rst,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [NUM_IN-1:0]  vec_in,
    input  logic [NUM_OUT-1:0] exp_in,
    input  logic [NUM_OUT-1:0] mask_in,
    input  logic               abort,
    input  logic               clr_cnt,
    output logic [NUM_IN-1:0]  x_out,
    input  logic [NUM_OUT-1:0] z_in,
    output logic               res_valid,
    output logic               res_pass,
    output logic [NUM_OUT-1:0] res_z,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic               busy
);

    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [7:0]         settle_cnt;
    logic [7:0]         settle_cnt_nx;
    logic [NUM_OUT-1:0] exp_q;
    logic [NUM_OUT-1:0] mask_q;
    logic               accept;
    logic               sample;
    logic               cmp_pass;
    logic [CNT_W-1:0]   pass_cnt_nx;
    logic [CNT_W-1:0]   fail_cnt_nx;

    assign vec_ready = (state == ST_IDLE) && !my_rst;
    assign busy      = (state == ST_WAIT);
    assign cmp_pass  = (((z_in ^ exp_q) & mask_q) == '0);

    // abort takes precedence over the sampling edge, so an aborted vector never reports
    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        accept        = 1'b0;
        sample        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (vec_valid && vec_ready) begin
                    accept        = 1'b1;
                    state_nx      = ST_WAIT;
                    settle_cnt_nx = SETTLE_LOAD;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (settle_cnt == 8'd0) begin
                    sample   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    settle_cnt_nx = settle_cnt - 8'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // clear beats a coincident increment; both counters stick at all-ones
    always_comb begin
        pass_cnt_nx = pass_cnt;
        fail_cnt_nx = fail_cnt;
        if (clr_cnt) begin
            pass_cnt_nx = '0;
            fail_cnt_nx = '0;
        end else if (sample) begin
            if (cmp_pass) begin
                if (pass_cnt != CNT_MAX) pass_cnt_nx = pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt_nx = fail_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge my_clk) begin
        if (my_rst) begin
            state      <= ST_IDLE;
            settle_cnt <= 8'd0;
            x_out      <= '0;
            exp_q      <= '0;
            mask_q     <= '0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
            res_z      <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            res_valid  <= sample;
            pass_cnt   <= pass_cnt_nx;
            fail_cnt   <= fail_cnt_nx;
            // x_out is never cleared here: the datapath behind it may be stateful
            if (accept) begin
                x_out  <= vec_in;
                exp_q  <= exp_in;
                mask_q <= mask_in;
            end
            if (sample) begin
                res_z    <= z_in;
                res_pass <= cmp_pass;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hw_vector_sequencer.sv
// Self-checking bench for hw_vector_sequencer: directed scenarios plus random
// traffic, compared every cycle against a cycle-scheduled behavioural model.
`default_nettype none

module tb_hw_vector_sequencer;

    localparam int SETTLE = 2;

    logic        my_clk;
    logic        my_rst;
    logic        vec_valid;
    logic [38:0] vec_in;
    logic [2:0]  exp_in;
    logic [2:0]  mask_in;
    logic        abort;
    logic        clr_cnt;
    logic [2:0]  z_in;

    logic        vec_ready, res_valid, res_pass, busy;
    logic [38:0] x_out;
    logic [2:0]  res_z;
    logic [15:0] pass_cnt, fail_cnt;

    logic        vec_ready2, res_valid2, res_pass2, busy2;
    logic [38:0] x_out2;
    logic [2:0]  res_z2;
    logic [1:0]  pass_cnt2, fail_cnt2;

    int checks = 0;
    int errors = 0;

    hw_vector_sequencer #(.NUM_IN(39), .NUM_OUT(3), .SETTLE(SETTLE), .CNT_W(16)) dut (
        .my_clk(my_clk), .my_rst(my_rst), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_in(vec_in), .exp_in(exp_in), .mask_in(mask_in), .abort(abort),
        .clr_cnt(clr_cnt), .x_out(x_out), .z_in(z_in), .res_valid(res_valid),
        .res_pass(res_pass), .res_z(res_z), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .busy(busy)
    );

    hw_vector_sequencer #(.NUM_IN(39), .NUM_OUT(3), .SETTLE(SETTLE), .CNT_W(2)) dut2 (
        .my_clk(my_clk), .my_rst(my_rst), .vec_valid(vec_valid), .vec_ready(vec_ready2),
        .vec_in(vec_in), .exp_in(exp_in), .mask_in(mask_in), .abort(abort),
        .clr_cnt(clr_cnt), .x_out(x_out2), .z_in(z_in), .res_valid(res_valid2),
        .res_pass(res_pass2), .res_z(res_z2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
        .busy(busy2)
    );

    initial my_clk = 1'b0;
    always #5 my_clk = ~my_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A vector accepted at edge n reports at edge n+SETTLE unless aborted or reset.
    longint      cyc = 0;
    longint      m_due = 0;
    bit          m_busy = 0;
    logic [38:0] m_x = '0;
    logic [2:0]  m_exp = '0, m_mask = '0;
    bit          m_rv = 0, m_rp = 0;
    logic [2:0]  m_rz = '0;
    int          m_pass = 0, m_fail = 0, m_pass2 = 0, m_fail2 = 0;

    function automatic int bump(input int c, input int maxv);
        return (c < maxv) ? c + 1 : c;
    endfunction

    initial begin
        forever begin
            @(posedge my_clk);
            #1;
            cyc++;
            if (my_rst) begin
                m_busy = 0; m_x = '0; m_rv = 0; m_rp = 0; m_rz = '0;
                m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
            end else begin
                bit done;
                bit ok;
                done = 0;
                ok   = 0;
                m_rv = 0;
                if (!m_busy) begin
                    if (vec_valid) begin
                        m_busy = 1; m_x = vec_in; m_exp = exp_in; m_mask = mask_in;
                        m_due = cyc + SETTLE;
                    end
                end else if (abort) begin
                    m_busy = 0;
                end else if (cyc == m_due) begin
                    m_busy = 0; done = 1;
                    ok = (((z_in ^ m_exp) & m_mask) == 3'b000);
                    m_rv = 1; m_rz = z_in; m_rp = ok;
                end
                if (clr_cnt) begin
                    m_pass = 0; m_fail = 0; m_pass2 = 0; m_fail2 = 0;
                end else if (done) begin
                    if (ok) begin
                        m_pass = bump(m_pass, 65535); m_pass2 = bump(m_pass2, 3);
                    end else begin
                        m_fail = bump(m_fail, 65535); m_fail2 = bump(m_fail2, 3);
                    end
                end
            end
            chk("vec_ready", vec_ready, !m_busy && !my_rst);
            chk("busy", busy, m_busy);
            chk("x_out", x_out, m_x);
            chk("res_valid", res_valid, m_rv);
            chk("res_pass", res_pass, m_rp);
            chk("res_z", res_z, m_rz);
            chk("pass_cnt", pass_cnt, m_pass);
            chk("fail_cnt", fail_cnt, m_fail);
            chk("pass_cnt_w2", pass_cnt2, m_pass2);
            chk("fail_cnt_w2", fail_cnt2, m_fail2);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [38:0] v, input logic [2:0] e, input logic [2:0] m,
                        input logic [2:0] z, input bit clr_at_sample, output int lat);
        int guard;
        guard = 0;
        @(negedge my_clk);
        while (!vec_ready && guard < 20) begin
            @(negedge my_clk);
            guard++;
        end
        chk("ready_timeout", (guard < 20), 1'b1);
        vec_valid = 1; vec_in = v; exp_in = e; mask_in = m; z_in = z;
        @(negedge my_clk);
        vec_valid = 0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            clr_cnt = clr_at_sample && (lat == SETTLE);
            @(negedge my_clk);
            clr_cnt = 0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int hs;
        int rv;
        logic [38:0] av;
        my_rst = 1; vec_valid = 0; vec_in = '0; exp_in = '0; mask_in = '0;
        abort = 0; clr_cnt = 0; z_in = '0;

        // reset state
        repeat (3) @(negedge my_clk);
        chk("rst_x_out", x_out, 39'd0);
        chk("rst_ready", vec_ready, 1'b0);
        chk("rst_pass_cnt", pass_cnt, 16'd0);
        my_rst = 0;
        @(negedge my_clk);
        chk("ready_after_rst", vec_ready, 1'b1);

        // scenario 1: x00 only, exact match
        send(39'd1, 3'b101, 3'b111, 3'b101, 0, lat);
        chk("s1_latency", lat, SETTLE + 1);
        chk("s1_res_pass", res_pass, 1'b1);
        chk("s1_res_z", res_z, 3'b101);
        chk("s1_pass_cnt", pass_cnt, 16'd1);
        chk("s1_x_out", x_out, 39'd1);

        // scenario 2: mismatch on bit 0, then masked away
        send(39'h40_0000_0001, 3'b101, 3'b111, 3'b100, 0, lat);
        chk("s2_res_pass", res_pass, 1'b0);
        chk("s2_fail_cnt", fail_cnt, 16'd1);
        send(39'h40_0000_0001, 3'b101, 3'b110, 3'b100, 0, lat);
        chk("s2_masked_pass", res_pass, 1'b1);
        chk("s2_pass_cnt", pass_cnt, 16'd2);

        // scenario 3: valid held high across four vectors
        @(negedge my_clk);
        vec_valid = 1; exp_in = 3'b011; mask_in = 3'b111; z_in = 3'b011;
        hs = 0; rv = 0;
        for (int i = 0; i < 12; i++) begin
            if (vec_ready) hs++;
            vec_in = {7'd0, $urandom};
            @(negedge my_clk);
            if (res_valid) rv++;
        end
        vec_valid = 0;
        repeat (3) begin
            @(negedge my_clk);
            if (res_valid) rv++;
        end
        chk("s3_handshakes", hs, 4);
        chk("s3_results", rv, 4);
        chk("s3_pass_cnt", pass_cnt, 16'd6);

        // scenario 4: saturation of the 2-bit counters, then clear wins
        clr_cnt = 1;
        @(negedge my_clk);
        clr_cnt = 0;
        for (int i = 0; i < 5; i++) send(39'(i), 3'b000, 3'b000, 3'b111, 0, lat);
        chk("s4_sat_pass_w2", pass_cnt2, 2'd3);
        chk("s4_pass_cnt", pass_cnt, 16'd5);
        send(39'h7f_ffff_ffff, 3'b000, 3'b000, 3'b111, 1, lat);
        chk("s4_clr_res_valid", res_valid, 1'b1);
        chk("s4_clr_res_pass", res_pass, 1'b1);
        chk("s4_clr_pass_w2", pass_cnt2, 2'd0);
        chk("s4_clr_pass", pass_cnt, 16'd0);

        // scenario 5: abort one cycle after handshake
        av = 39'h2a_5a5a_a5a5;
        @(negedge my_clk);
        vec_valid = 1; vec_in = av; exp_in = 3'b111; mask_in = 3'b111; z_in = 3'b000;
        @(negedge my_clk);
        vec_valid = 0; abort = 1;
        @(negedge my_clk);
        abort = 0;
        chk("s5_ready", vec_ready, 1'b1);
        chk("s5_x_kept", x_out, av);
        rv = 0;
        repeat (4) begin
            if (res_valid) rv++;
            @(negedge my_clk);
        end
        chk("s5_no_result", rv, 0);
        chk("s5_fail_cnt", fail_cnt, 16'd0);

        // scenario 6: reset during WAIT, then a fresh vector
        vec_valid = 1; vec_in = 39'h11; exp_in = 3'b000; mask_in = 3'b111;
        @(negedge my_clk);
        vec_valid = 0; my_rst = 1;
        @(negedge my_clk);
        chk("s6_x_cleared", x_out, 39'd0);
        chk("s6_busy", busy, 1'b0);
        chk("s6_res_valid", res_valid, 1'b0);
        my_rst = 0;
        send(39'd1, 3'b101, 3'b111, 3'b101, 0, lat);
        chk("s6_latency", lat, SETTLE + 1);
        chk("s6_pass_cnt", pass_cnt, 16'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge my_clk);
            vec_valid = ($urandom_range(0, 99) < 60);
            vec_in    = {7'($urandom), $urandom};
            exp_in    = 3'($urandom);
            mask_in   = 3'($urandom);
            z_in      = 3'($urandom);
            abort     = ($urandom_range(0, 99) < 6);
            clr_cnt   = ($urandom_range(0, 99) < 3);
            my_rst    = ($urandom_range(0, 999) < 5);
        end
        @(negedge my_clk);
        vec_valid = 0; abort = 0; clr_cnt = 0; my_rst = 0;
        repeat (4) @(negedge my_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
